alu_serial_cmd_rx: RTL

- Receive side of the ALU serial command protocol.
- Deserializes 11-bit frames from `sin`.
- Assembles eight DATA bytes (B then A, MSB byte first) plus one CMD byte.
- Checks packet count, CRC4 and opcode validity, then presents either a decoded command or an error code to the ALU core, one cycle after the CMD frame ends.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_serial_frame_rx.sv | 72 +++++++
 rtl/alu_serial_cmd_rx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types, constants and CRC helper for the ALU serial command protocol.
package alu_pkg;

    typedef enum logic [2:0] {
        AND     = 3'b000,
        OR      = 3'b001,
        INV_010 = 3'b010,
        INV_011 = 3'b011,
        ADD     = 3'b100,
        SUB     = 3'b101,
        INV_110 = 3'b110,
        INV_111 = 3'b111
    } operation_t;

    typedef enum logic {
        DATA = 1'b0,
        CMD  = 1'b1
    } packet_type_t;

    // Encoded directly as the {err_data, err_crc, err_op} flag vector.
    typedef enum logic [2:0] {
        ERR_NONE = 3'b000,
        ERR_OP   = 3'b001,
        ERR_CRC  = 3'b010,
        ERR_DATA = 3'b100
    } processing_error_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Serial CRC4, polynomial x^4+x+1, data consumed MSB first.
    function automatic logic [3:0] CRC4_D68(input logic [67:0] data, input logic [3:0] crc_in);
        logic [3:0] c;
        logic       fb;
        c = crc_in;
        for (int unsigned i = 0; i < 68; i++) begin
            fb = c[3] ^ data[67 - i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic op_supported(input operation_t op);
        return (op == AND) || (op == OR) || (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/alu_serial_frame_rx.sv
// Bit-level receiver for 11-bit frames: start, type, d7..d0, stop.
// With ALU_RX_TIMEOUT_EN defined an extra `idle` status output is present.
module alu_serial_frame_rx
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sin,
    output logic         frame_valid,
    output packet_type_t frame_type,
    output logic [7:0]   frame_byte,
`ifdef ALU_RX_TIMEOUT_EN
    output logic         idle,
`endif
    output logic         frame_err
);

    typedef enum logic [1:0] {S_IDLE, S_TYPE, S_DATA, S_STOP} state_t;

    state_t       state;
    logic [2:0]   bit_cnt;
    logic [7:0]   shreg;
    packet_type_t type_q;

`ifdef ALU_RX_TIMEOUT_EN
    assign idle = (state == S_IDLE);
`endif

    // Frame FSM with registered one-cycle result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            type_q      <= DATA;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_type  <= DATA;
            frame_byte  <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sin == START_BIT) state <= S_TYPE;
                end
                S_TYPE: begin
                    type_q  <= packet_type_t'(sin);
                    bit_cnt <= 3'd7;
                    state   <= S_DATA;
                end
                S_DATA: begin
                    shreg <= {shreg[6:0], sin};
                    if (bit_cnt == '0) state <= S_STOP;
                    else               bit_cnt <= bit_cnt - 3'd1;
                end
                S_STOP: begin
                    if (sin == STOP_BIT) begin
                        frame_valid <= 1'b1;
                        frame_type  <= type_q;
                        frame_byte  <= shreg;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_serial_cmd_rx.sv
// ALU serial command receiver: assembles 8 DATA bytes + 1 CMD byte, checks
// count/CRC/opcode and emits a decoded command or an error pulse.
// Optional idle timeout on partial commands: define ALU_RX_TIMEOUT_EN.
module alu_serial_cmd_rx
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        cmd_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output operation_t  op_set,
    output logic        err_valid,
    output logic [2:0]  err_flags
);

    logic         frame_valid;
    logic         frame_err;
    packet_type_t frame_type;
    logic [7:0]   frame_byte;

    logic [63:0]  data_sr;
    logic [3:0]   data_cnt;
    logic         frame_bad;

    operation_t   rx_op;
    logic [3:0]   crc_exp;
    logic         op_ok;
    logic         timeout_hit;

`ifdef ALU_RX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic             fsm_idle;
    logic [CNT_W-1:0] idle_cnt;
`endif

    alu_serial_frame_rx u_frame_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (sin),
        .frame_valid (frame_valid),
        .frame_type  (frame_type),
        .frame_byte  (frame_byte),
`ifdef ALU_RX_TIMEOUT_EN
        .idle        (fsm_idle),
`endif
        .frame_err   (frame_err)
    );

    // Checks on the CMD byte against the assembled operands.
    always_comb begin
        rx_op   = operation_t'(frame_byte[6:4]);
        crc_exp = CRC4_D68({data_sr, 1'b1, frame_byte[6:4]}, 4'b0000);
        op_ok   = !frame_byte[7] && op_supported(rx_op);
    end

`ifdef ALU_RX_TIMEOUT_EN
    // Timeout fires while idle mid-command; a start bit aborts the count.
    assign timeout_hit = fsm_idle && (data_cnt != '0) && sin &&
                         (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Idle cycle counter for partial-command expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                              idle_cnt <= '0;
        else if (!fsm_idle || data_cnt == '0 || !sin || timeout_hit) idle_cnt <= '0;
        else                                                     idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Command assembly, checking and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sr   <= '0;
            data_cnt  <= '0;
            frame_bad <= 1'b0;
            cmd_valid <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= '0;
            A         <= '0;
            B         <= '0;
            op_set    <= AND;
        end else begin
            cmd_valid <= 1'b0;
            err_valid <= 1'b0;
            if (frame_err) begin
                frame_bad <= 1'b1;
            end else if (frame_valid && frame_type == DATA) begin
                data_sr <= {data_sr[55:0], frame_byte};
                if (data_cnt != 4'd9) data_cnt <= data_cnt + 4'd1;
            end else if (frame_valid) begin
                if (data_cnt != 4'd8 || frame_bad) begin
                    err_valid <= 1'b1;
                    err_flags <= ERR_DATA;
                end else if (frame_byte[3:0] != crc_exp) begin
                    err_valid <= 1'b1;
                    err_flags <= ERR_CRC;
                end else if (!op_ok) begin
                    err_valid <= 1'b1;
                    err_flags <= ERR_OP;
                end else begin
                    cmd_valid <= 1'b1;
                    B         <= data_sr[63:32];
                    A         <= data_sr[31:0];
                    op_set    <= rx_op;
                end
                data_cnt  <= '0;
                frame_bad <= 1'b0;
            end else if (timeout_hit) begin
                data_cnt  <= '0;
                frame_bad <= 1'b0;
            end
        end
    end

endmodule
